// File: rtl/cam_lookup_ctrl.sv
// cam_lookup_ctrl: lookup-or-insert controller in front of a CAM.
// Searches the CAM for an exact key. On a hit it returns the matched index.
// On a miss it allocates the lowest free entry, or a round-robin victim when
// the CAM is full, writes the key there and returns the new index. Entries
// can also be invalidated by index. Occupancy is tracked in a valid bitmap.
//
// Optional feature macro: CAM_LOOKUP_STAT_EN adds saturating 32-bit
// hit/miss/evict statistics counters (stat_hit, stat_miss, stat_evict).
//
// Ports:
//   clk, reset_          clock, async active-low reset
//   req_, req_key        active-low lookup request and its key
//   inv_, inv_idx        active-low invalidate of one entry (IDLE only)
//   busy                 request in flight (LOOKUP/INSERT/RESP)
//   resp_                one-cycle active-low response strobe
//   resp_hit/idx/evict   response payload, held until the next response
//   count, full          number of valid entries, count == DEPTH
//   cam_re_/rm/rd        CAM read (search) port
//   cam_match/raddr      CAM search result
//   cam_we_/wm/wd/waddr  CAM write port (wm bit 1 = bit not written)
module cam_lookup_ctrl #(
    parameter int unsigned KEY   = 15,
    parameter int unsigned DEPTH = 64,
    parameter int unsigned ADDR  = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset_,
    input  logic            req_,
    input  logic [KEY-1:0]  req_key,
    input  logic            inv_,
    input  logic [ADDR-1:0] inv_idx,
    output logic            busy,
    output logic            resp_,
    output logic            resp_hit,
    output logic [ADDR-1:0] resp_idx,
    output logic            resp_evict,
    output logic [ADDR:0]   count,
    output logic            full,
`ifdef CAM_LOOKUP_STAT_EN
    output logic [31:0]     stat_hit,
    output logic [31:0]     stat_miss,
    output logic [31:0]     stat_evict,
`endif
    output logic            cam_re_,
    output logic [KEY:0]    cam_rm,
    output logic [KEY:0]    cam_rd,
    input  logic            cam_match,
    input  logic [ADDR-1:0] cam_raddr,
    output logic            cam_we_,
    output logic [KEY:0]    cam_wm,
    output logic [KEY:0]    cam_wd,
    output logic [ADDR-1:0] cam_waddr
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOOKUP = 2'd1;
    localparam logic [1:0] S_INSERT = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam logic [ADDR:0]   DEPTH_CNT = (ADDR+1)'(DEPTH);
    localparam logic [ADDR-1:0] LAST_IDX  = ADDR'(DEPTH - 1);
    // Invalidate writes only the tag bit (to 0); key bits are left untouched.
    localparam logic [KEY:0]    TAG_ONLY_WM = {1'b0, {KEY{1'b1}}};

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [KEY-1:0]   r_key;
    logic [DEPTH-1:0] r_valid;
    logic [ADDR-1:0]  r_rr_ptr;
    logic [ADDR:0]    r_count;
    logic             r_resp_n;
    logic             r_resp_hit;
    logic [ADDR-1:0]  r_resp_idx;
    logic             r_resp_evict;

    logic             w_full;
    logic             w_accept;
    logic             w_inv;
    logic             w_hit;
    logic             w_insert;
    logic [ADDR-1:0]  w_free_idx;
    logic [ADDR-1:0]  w_victim;
    logic [ADDR-1:0]  w_rr_next;

    assign w_full    = (r_count == DEPTH_CNT);
    assign w_inv     = (r_state == S_IDLE) && !inv_;
    assign w_accept  = (r_state == S_IDLE) && inv_ && !req_;
    assign w_hit     = (r_state == S_LOOKUP) && cam_match;
    assign w_insert  = (r_state == S_INSERT);
    assign w_victim  = w_full ? r_rr_ptr : w_free_idx;
    assign w_rr_next = (r_rr_ptr == LAST_IDX) ? '0 : r_rr_ptr + ADDR'(1);

    // Lowest index whose valid bit is clear.
    always_comb begin
        w_free_idx = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_free_idx = ADDR'(i);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = S_LOOKUP;
            S_LOOKUP: w_next = cam_match ? S_RESP : S_INSERT;
            S_INSERT: w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Key, valid bitmap, occupancy, round-robin pointer and response payload.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_key        <= '0;
            r_valid      <= '0;
            r_rr_ptr     <= '0;
            r_count      <= '0;
            r_resp_n     <= 1'b1;
            r_resp_hit   <= 1'b0;
            r_resp_idx   <= '0;
            r_resp_evict <= 1'b0;
        end else begin
            if (w_accept) begin
                r_key <= req_key;
            end
            // Re-invalidating an invalid entry must not touch the count.
            if (w_inv) begin
                r_valid[inv_idx] <= 1'b0;
                if (r_valid[inv_idx]) begin
                    r_count <= r_count - (ADDR+1)'(1);
                end
            end
            if (w_insert) begin
                r_valid[w_victim] <= 1'b1;
                if (w_full) begin
                    r_rr_ptr <= w_rr_next;
                end else begin
                    r_count <= r_count + (ADDR+1)'(1);
                end
            end
            r_resp_n <= (w_next != S_RESP);
            if (w_hit) begin
                r_resp_hit   <= 1'b1;
                r_resp_idx   <= cam_raddr;
                r_resp_evict <= 1'b0;
            end
            if (w_insert) begin
                r_resp_hit   <= 1'b0;
                r_resp_idx   <= w_victim;
                r_resp_evict <= w_full;
            end
        end
    end

`ifdef CAM_LOOKUP_STAT_EN
    logic [31:0] r_stat_hit;
    logic [31:0] r_stat_miss;
    logic [31:0] r_stat_evict;

    // Saturating outcome counters; updated on the edge entering RESP.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_stat_hit   <= '0;
            r_stat_miss  <= '0;
            r_stat_evict <= '0;
        end else begin
            if (w_hit && (r_stat_hit != '1)) begin
                r_stat_hit <= r_stat_hit + 32'd1;
            end
            if (w_insert && (r_stat_miss != '1)) begin
                r_stat_miss <= r_stat_miss + 32'd1;
            end
            if (w_insert && w_full && (r_stat_evict != '1)) begin
                r_stat_evict <= r_stat_evict + 32'd1;
            end
        end
    end

    assign stat_hit   = r_stat_hit;
    assign stat_miss  = r_stat_miss;
    assign stat_evict = r_stat_evict;
`endif

    // CAM port drive; write port is shared by invalidate (IDLE) and insert.
    always_comb begin
        cam_re_   = 1'b1;
        cam_we_   = 1'b1;
        cam_waddr = inv_idx;
        cam_wd    = '0;
        cam_wm    = TAG_ONLY_WM;
        case (r_state)
            S_IDLE:   if (!inv_) cam_we_ = 1'b0;
            S_LOOKUP: cam_re_ = 1'b0;
            S_INSERT: begin
                cam_we_   = 1'b0;
                cam_waddr = w_victim;
                cam_wd    = {1'b1, r_key};
                cam_wm    = '0;
            end
            default: ;
        endcase
    end

    assign cam_rd     = {1'b1, r_key};
    assign cam_rm     = '0;
    assign busy       = (r_state != S_IDLE);
    assign resp_      = r_resp_n;
    assign resp_hit   = r_resp_hit;
    assign resp_idx   = r_resp_idx;
    assign resp_evict = r_resp_evict;
    assign count      = r_count;
    assign full       = w_full;

endmodule

// File: doc/cam_lookup_ctrl.md
Name: cam_lookup_ctrl

Overview:
Lookup-or-insert controller sitting directly upstream of the cam block and driving one of its write ports and one of its read ports. It accepts exact-match key requests and searches the CAM. On a hit it returns the matched index. On a miss it allocates an entry (lowest free index, or a round-robin victim when full), writes the key, and returns the new index. It also tracks occupancy and supports explicit invalidation by index.

Parameters:
KEY, 15, key width in bits; the CAM data width is KEY+1.
DEPTH, 64, number of CAM entries; must match the cam instance.
ADDR, $clog2(DEPTH), index width (derived; do not override).

Ports:
clk  in  1  clock
reset_  in  1  asynchronous active-low reset
req_  in  1  active-low lookup request; accepted when busy=0 and inv_=1
req_key  in  KEY  key sampled on accept
inv_  in  1  active-low invalidate, honoured only when busy=0
inv_idx  in  ADDR  entry to invalidate
busy  out  1  high from the cycle after accept until the RESP cycle, inclusive
resp_  out  1  active-low response strobe, one cycle
resp_hit  out  1  1 = key was present
resp_idx  out  ADDR  hit or allocated index
resp_evict  out  1  1 = a valid entry was overwritten (miss while full)
count  out  ADDR+1  number of valid entries
full  out  1  count == DEPTH
cam_re_  out  1  to cam re_ (one read port)
cam_rm  out  KEY+1  to cam rm; always 0 (exact match including tag)
cam_rd  out  KEY+1  to cam rd; {1'b1, key}
cam_match  in  1  from cam match
cam_raddr  in  ADDR  from cam raddr
cam_we_  out  1  to cam we_ (one write port)
cam_wm  out  KEY+1  to cam wm (1 = bit not written)
cam_wd  out  KEY+1  to cam wd
cam_waddr  out  ADDR  to cam waddr

Behaviour:
- Tag bit: CAM bit [KEY] is the entry valid tag.
  - Inserts write {1, key} with wm=0.
  - Invalidate writes wd[KEY]=0 with wm = all ones except bit KEY.
  - Lookups compare the tag as 1, so reset-zero or invalidated cells never match. This also covers key 0 after reset.
- Internal valid[DEPTH] bitmap mirrors the tags. It sources count, full and allocation.
- FSM IDLE -> LOOKUP -> (hit) RESP | (miss) INSERT -> RESP -> IDLE.
- IDLE:
  - busy=0.
  - If inv_=0: drive cam_we_=0 combinationally with cam_waddr=inv_idx and clear valid[inv_idx] at the edge. req_ is ignored in that cycle (inv_ wins).
  - Else if req_=0: latch the key and go to LOOKUP.
- LOOKUP:
  - cam_re_=0, cam_rd={1,key}; sample cam_match and cam_raddr at the edge.
  - Hit: resp_hit=1, resp_idx=cam_raddr, go to RESP.
  - Miss: go to INSERT.
- INSERT:
  - Victim = lowest index with valid=0. If full, victim = rr_ptr, resp_evict=1, and rr_ptr increments, wrapping DEPTH-1 -> 0.
  - cam_we_=0, cam_waddr=victim, cam_wd={1,key}, cam_wm=0; set valid[victim].
  - resp_hit=0, resp_idx=victim.
- RESP: resp_=0 for exactly one cycle (registered outputs), then IDLE.
- Latency, with accept at edge T:
  - hit: resp_ low in cycle T+2.
  - miss: resp_ low in cycle T+3.
  - Next accept is possible in cycle T+3 (hit) or T+4 (miss).
- cam_re_ and cam_we_ are 1 in all other states/cycles. Insert and invalidate never overlap.
- An insert never creates a duplicate key, because insertion happens only after a miss.
- count updates on the edge after insert or invalidate. Invalidating an already-invalid index leaves count unchanged (the CAM write is harmless).
- resp_hit, resp_idx and resp_evict hold their values until the next RESP.
- Reset (async, any state):
  - FSM=IDLE, valid=0, rr_ptr=0, count=0.
  - busy=0, resp_=1, resp_hit=0, resp_idx=0, resp_evict=0.
  - cam_re_=1, cam_we_=1.
  - A request in flight is dropped with no response. The cam shares reset_ and clears in the same event.

Optional Feature:
CAM_LOOKUP_STAT_EN:
- Defined: adds outputs stat_hit, stat_miss, stat_evict (32 bits each).
  - Each increments by 1 in the RESP cycle of the matching outcome.
  - Each saturates at 0xFFFFFFFF and resets to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset -> busy=0, resp_=1, count=0, full=0, cam_we_=1, cam_re_=1; lookup of key 0x0000 -> resp_hit=0, allocated idx 0 (tag blocks reset cells).
- Request key 0x0005 from empty -> resp_ low at T+3, resp_hit=0, resp_idx=0, count=1; repeat key 0x0005 -> resp_ low at T+2, resp_hit=1, resp_idx=0, count=1.
- Insert keys 0x100..0x13F (64 misses) -> idx 0..63 in order, full=1; key 0x200 -> resp_evict=1, resp_idx=0; key 0x201 -> resp_idx=1 (rr_ptr wrap checked after 64 evictions, idx 63 -> 0).
- After fill, inv_=0 with inv_idx=3 -> count 64->63; lookup 0x103 -> miss, reinserted at idx 3, resp_evict=0.
- inv_=0 and req_=0 in the same IDLE cycle -> invalidate only; req_ held -> accepted next cycle; inv_ asserted while busy=1 -> ignored, valid unchanged.
- reset_ low during INSERT -> no resp_ strobe, count=0, next request for the same key -> miss, idx 0.
